// File: rtl/link_pkg.sv
// Shared types and sizing helpers for the subnode link master and its arbiter.
package link_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    RECV = 3'd4,
    DONE = 3'd5
  } link_state_t;

  localparam int DEFAULT_TIMEOUT = 4096;

  function automatic int msg_width(input int nb);
    return 32 * nb;
  endfunction

  function automatic int key_width(input int nk);
    return 32 * nk;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers the last granted client.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  // last == 1 means client 1 was served last, so client 0 has priority
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (last) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (grant_en && (gnt != 2'b00)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/subnode_link_master.sv
// Serial link sequencer: arbitrates two clients, shifts {msg,key} out, collects the result.
// Optional WAIT-state watchdog enabled by defining LINK_WATCHDOG_EN.
module subnode_link_master
  import link_pkg::*;
#(
  parameter int NK      = 8,
  parameter int NB      = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              in_clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [32*NB-1:0]  msg0,
  input  logic [32*NB-1:0]  msg1,
  input  logic [32*NK-1:0]  key0,
  input  logic [32*NK-1:0]  key1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              err,
  output logic [32*NB-1:0]  res_data,
  output logic              busy,
  output logic              cs,
  output logic              in_valid,
  output logic              sdi,
  input  logic              sdo,
  input  logic              sub_out_valid,
  output logic [2:0]        dbg_state
);

  localparam int MSG_W = msg_width(NB);
  localparam int KEY_W = key_width(NK);
  localparam int TOT_W = MSG_W + KEY_W;
  localparam int CNT_W = $clog2(TOT_W + 1);

  link_state_t      state_q, state_d;
  logic [TOT_W-1:0] sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MSG_W-2:0] rx_q;
  logic [MSG_W-1:0] res_q;
  logic [1:0]       gnt_q;
  logic [1:0]       arb_gnt;
  logic             timeout_hit;

  rr_arb2 u_arb (
    .clk      (in_clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant_en (state_q == IDLE),
    .gnt      (arb_gnt)
  );

`ifdef LINK_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign timeout_hit = (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != WAIT) wd_q <= '0;
      else                 wd_q <= wd_q + 1'b1;
      if (state_q == IDLE)
        err_q <= 1'b0;
      else if (state_q == WAIT && !sub_out_valid && timeout_hit)
        err_q <= 1'b1;
    end
  end

  assign err = (state_q == DONE) & err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (arb_gnt != 2'b00) state_d = SEL;
      SEL:  state_d = SEND;
      SEND: if (cnt_q == CNT_W'(TOT_W - 1)) state_d = WAIT;
      WAIT: begin
        if (sub_out_valid)    state_d = RECV;
        else if (timeout_hit) state_d = DONE;
      end
      RECV: if (cnt_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      rx_q  <= '0;
      res_q <= '0;
      gnt_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q <= arb_gnt;
          cnt_q <= '0;
          if (arb_gnt[1])      sh_q <= {msg1, key1};
          else if (arb_gnt[0]) sh_q <= {msg0, key0};
        end
        SEND: begin
          sh_q  <= {sh_q[TOT_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        WAIT: begin
          if (sub_out_valid) begin
            rx_q  <= {rx_q[MSG_W-3:0], sdo};
            cnt_q <= CNT_W'(MSG_W - 2);
          end else if (timeout_hit) begin
            res_q <= '0;
          end
        end
        RECV: begin
          // Bit count decides the end of capture; sub_out_valid is not rechecked here
          rx_q  <= {rx_q[MSG_W-3:0], sdo};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) res_q <= {rx_q, sdo};
        end
        DONE: gnt_q <= 2'b00;
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign cs        = !(state_q inside {SEL, SEND, WAIT, RECV});
  assign in_valid  = (state_q == SEND);
  assign sdi       = in_valid & sh_q[TOT_W-1];
  assign gnt       = (state_q == DONE) ? 2'b00 : gnt_q;
  assign done      = (state_q == DONE) ? gnt_q : 2'b00;
  assign res_data  = res_q;
  assign dbg_state = state_q;

endmodule
